wca_dsp_strobe_gen: RTL and testbench

WCA_DSP_STROBE_GEN -- requirements
Module: wca_dsp_strobe_gen

---
 rtl/wca_dsp_pkg.sv | 14 +
 rtl/wca_dsp_down_counter.sv | 34 +++
 rtl/wca_dsp_strobe_gen.sv | 127 ++++++++++++
 tb/tb_wca_dsp_strobe_gen.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/wca_dsp_pkg.sv
// Shared definitions for the wca_dsp strobe generator family.
// Holds the FSM state type and the default datapath widths.
package wca_dsp_pkg;

   localparam int DEF_MAXBITS = 24;
   localparam int DEF_CNTBITS = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/wca_dsp_down_counter.sv
// Loadable down-counter that stops at zero; load wins over decrement.
// zero_o decodes the registered value, so it carries no input-to-output path.
module wca_dsp_down_counter
   import wca_dsp_pkg::*;
#(
   parameter int WIDTH = DEF_MAXBITS + 1
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             en_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o,
   output logic             zero_o
);

   logic [WIDTH-1:0] q_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values and the simulation order of blocks cannot matter.
   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         q_q <= '0;
      end else if (load_i) begin
         q_q <= d_i;
      end else if (en_i && !zero_o) begin
         q_q <= q_q - WIDTH'(1);
      end
   end

   assign q_o    = q_q;
   assign zero_o = (q_q == '0);

endmodule

// File: rtl/wca_dsp_strobe_gen.sv
// Programmable-period strobe generator with deferred rate updates, phase
// sync, oneshot mode and a wrapping strobe tally; all outputs registered.
module wca_dsp_strobe_gen
   import wca_dsp_pkg::*;
#(
   parameter int MAXBITS = DEF_MAXBITS,
   parameter int CNTBITS = DEF_CNTBITS
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               enable_i,
   input  logic               oneshot_i,
   input  logic [MAXBITS:0]   rate_i,
   input  logic               rate_wr_i,
   input  logic               sync_i,
   output logic               strobe_o,
   output logic [MAXBITS:0]   count_o,
   output logic               pending_o,
   output logic               done_o,
   output logic [CNTBITS-1:0] tally_o
);

   state_e               state_q;
   logic [MAXBITS:0]     active_q;
   logic [MAXBITS:0]     pend_rate_q;
   logic                 pending_q;
   logic                 strobe_q;
   logic                 done_q;
   logic [CNTBITS-1:0]   tally_q;

   logic                 running;
   logic                 sync_act;
   logic                 term;
   logic                 cnt_zero;
   logic [MAXBITS:0]     next_rate;

   // NOTE: every always_comb output is assigned a default first, so no path
   // through the block can leave a value unassigned and infer a latch.
   always_comb begin
      running   = (state_q == ST_RUN) && enable_i;
      sync_act  = sync_i && (state_q != ST_IDLE);
      term      = running && cnt_zero && !sync_act;
      // A coincident write bypasses the pending register for this reload.
      next_rate = active_q;
      if (rate_wr_i) begin
         next_rate = rate_i;
      end else if (pending_q) begin
         next_rate = pend_rate_q;
      end
   end

   wca_dsp_down_counter #(
      .WIDTH (MAXBITS + 1)
   ) u_counter (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .en_i    (running),
      .load_i  (sync_act || term),
      .d_i     (next_rate),
      .q_o     (count_o),
      .zero_o  (cnt_zero)
   );

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         state_q     <= ST_IDLE;
         active_q    <= '0;
         pend_rate_q <= '0;
         pending_q   <= 1'b0;
         strobe_q    <= 1'b0;
         done_q      <= 1'b0;
         tally_q     <= '0;
      end else begin
         strobe_q <= term;
         if (term) begin
            tally_q <= tally_q + CNTBITS'(1);
         end

         // Any reload (terminal count or sync) consumes the pending write.
         if (sync_act || term) begin
            active_q  <= next_rate;
            pending_q <= 1'b0;
         end else if (rate_wr_i) begin
            pend_rate_q <= rate_i;
            pending_q   <= 1'b1;
         end

         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (enable_i) begin
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (!enable_i) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b0;
               end else if (term && oneshot_i) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end else begin
                  done_q <= 1'b0;
               end
            end
            ST_DONE: begin
               if (sync_i) begin
                  state_q <= enable_i ? ST_RUN : ST_IDLE;
                  done_q  <= 1'b0;
               end else begin
                  done_q <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign strobe_o  = strobe_q;
   assign pending_o = pending_q;
   assign done_o    = done_q;
   assign tally_o   = tally_q;

endmodule

// File: tb/tb_wca_dsp_strobe_gen.sv
// Bench for wca_dsp_strobe_gen: directed scenarios plus random traffic, all
// compared every cycle against a rule-level reference model.
module tb_wca_dsp_strobe_gen;

   localparam int MAXBITS = 24;
   localparam int CNTBITS = 4;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;

   logic               clock;
   logic               reset;
   logic               enable;
   logic               oneshot;
   logic [MAXBITS:0]   rate;
   logic               rate_wr;
   logic               sync;
   logic               strobe;
   logic [MAXBITS:0]   count;
   logic               pending;
   logic               done;
   logic [CNTBITS-1:0] tally;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: plain integers following the behavioural rules.
   int          m_st;
   int unsigned m_cnt;
   int unsigned m_act;
   int unsigned m_prate;
   bit          m_pend;
   bit          m_strobe;
   int unsigned m_tally;

   wca_dsp_strobe_gen #(
      .MAXBITS (MAXBITS),
      .CNTBITS (CNTBITS)
   ) dut (
      .clock_i   (clock),
      .reset_i   (reset),
      .enable_i  (enable),
      .oneshot_i (oneshot),
      .rate_i    (rate),
      .rate_wr_i (rate_wr),
      .sync_i    (sync),
      .strobe_o  (strobe),
      .count_o   (count),
      .pending_o (pending),
      .done_o    (done),
      .tally_o   (tally)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input bit en, input bit os, input int unsigned rt,
                             input bit wr, input bit sy, input bit rs);
      bit          run;
      bit          sa;
      bit          tc;
      int unsigned nr;
      if (!rs) begin
         m_st = M_IDLE; m_cnt = 0; m_act = 0; m_prate = 0;
         m_pend = 0; m_strobe = 0; m_tally = 0;
         return;
      end
      run = (m_st == M_RUN) && en;
      sa  = sy && (m_st != M_IDLE);
      tc  = run && (m_cnt == 0) && !sa;
      nr  = wr ? rt : (m_pend ? m_prate : m_act);
      m_strobe = tc;
      if (tc) m_tally = (m_tally + 1) % (1 << CNTBITS);
      if (sa || tc) begin
         m_cnt = nr; m_act = nr; m_pend = 0;
      end else begin
         if (wr) begin m_prate = rt; m_pend = 1; end
         if (run && m_cnt != 0) m_cnt = m_cnt - 1;
      end
      case (m_st)
         M_IDLE:  if (en) m_st = M_RUN;
         M_RUN:   if (!en) m_st = M_IDLE; else if (tc && os) m_st = M_DONE;
         default: if (sy) m_st = en ? M_RUN : M_IDLE;
      endcase
   endtask

   task automatic step(input bit en, input bit os, input int unsigned rt,
                       input bit wr, input bit sy, input bit rs);
      enable  = en;
      oneshot = os;
      rate    = (MAXBITS+1)'(rt);
      rate_wr = wr;
      sync    = sy;
      reset   = rs;
      @(posedge clock);
      model_edge(en, os, rt, wr, sy, rs);
      #1;
      check("strobe",  32'(strobe),  32'(m_strobe));
      check("count",   32'(count),   m_cnt);
      check("pending", 32'(pending), 32'(m_pend));
      check("done",    32'(done),    32'(m_st == M_DONE));
      check("tally",   32'(tally),   m_tally);
   endtask

   initial begin
      int prev;
      int k;
      int nstb;
      bit en_r, os_r, wr_r, sy_r, rs_r;
      int unsigned rt_r;

      enable = 0; oneshot = 0; rate = '0; rate_wr = 0; sync = 0; reset = 0;
      m_st = M_IDLE; m_cnt = 0; m_act = 0; m_prate = 0;
      m_pend = 0; m_strobe = 0; m_tally = 0;

      // Reset state
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      check("rst_count", 32'(count), 0);

      // Rate 3 written in IDLE, then a steady 4-clock period
      step(0, 0, 3, 1, 0, 1);
      check("pend_idle", 32'(pending), 1);
      prev = -1;
      for (int i = 0; i < 14; i++) begin
         step(1, 0, 3, 0, 0, 1);
         if (strobe) begin
            if (prev >= 0) check("period4", 32'(i - prev), 4);
            prev = i;
         end
      end

      // Rate 9 active, rate 2 written mid-period stays pending until reload
      step(1, 0, 9, 1, 0, 1);
      k = 0;
      do begin step(1, 0, 9, 0, 0, 1); k++; end while (!m_strobe && k < 20);
      check("tc9_reached", 32'(m_strobe), 1);
      check("reload9", 32'(count), 9);
      for (int i = 0; i < 3; i++) step(1, 0, 9, 0, 0, 1);
      step(1, 0, 2, 1, 0, 1);
      check("pend_mid", 32'(pending), 1);
      k = 0;
      do begin
         step(1, 0, 2, 0, 0, 1); k++;
         if (!m_strobe) check("pend_hold", 32'(pending), 1);
      end while (!m_strobe && k < 20);
      check("tc2_reached", 32'(m_strobe), 1);
      check("reload2", 32'(count), 2);
      check("pend_clear", 32'(pending), 0);
      k = 0;
      do begin step(1, 0, 2, 0, 0, 1); k++; end while (!m_strobe && k < 20);
      check("period3", 32'(k), 3);

      // Write coincident with terminal count bypasses the pending register
      k = 0;
      do begin step(1, 0, 5, 0, 0, 1); k++; end while (m_cnt != 0 && k < 20);
      check("zero_reached", 32'(count), 0);
      step(1, 0, 5, 1, 0, 1);
      check("bypass_strobe", 32'(strobe), 1);
      check("bypass_count", 32'(count), 5);
      check("bypass_pend", 32'(pending), 0);

      // Oneshot with rate 2, then sync restarts
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 2, 1, 0, 1);
      nstb = 0;
      for (int i = 0; i < 10; i++) begin
         step(1, 1, 2, 0, 0, 1);
         if (strobe) nstb++;
      end
      check("oneshot_cnt", 32'(nstb), 1);
      check("oneshot_done", 32'(done), 1);
      check("oneshot_hold", 32'(count), 2);
      step(1, 1, 2, 0, 1, 1);
      check("sync_done", 32'(done), 0);
      check("sync_count", 32'(count), 2);

      // Rate 0 strobes every RUN cycle; 4-bit tally wraps
      step(0, 0, 0, 0, 0, 0);
      nstb = 0;
      for (int i = 0; i < 20; i++) begin
         step(1, 0, 0, 0, 0, 1);
         if (strobe) nstb++;
      end
      check("rate0_strobes", 32'(nstb), 19);
      check("rate0_tally", 32'(tally), 3);

      // Reset mid-period with a pending write
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 9, 1, 0, 1);
      k = 0;
      do begin step(1, 0, 9, 0, 0, 1); k++; end while (m_cnt != 8 && k < 30);
      step(1, 0, 4, 1, 0, 1);
      check("pre_rst_count", 32'(count), 7);
      check("pre_rst_pend", 32'(pending), 1);
      step(1, 0, 4, 1, 1, 0);
      check("rst_count0", 32'(count), 0);
      check("rst_pend0", 32'(pending), 0);
      check("rst_tally0", 32'(tally), 0);
      check("rst_strobe0", 32'(strobe), 0);
      check("rst_done0", 32'(done), 0);
      step(0, 0, 0, 0, 0, 1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         en_r = ($urandom_range(0, 9) != 0);
         os_r = ($urandom_range(0, 9) == 0);
         wr_r = ($urandom_range(0, 9) == 0);
         rt_r = $urandom_range(0, 12);
         rs_r = ($urandom_range(0, 199) != 0);
         sy_r = ($urandom_range(0, 19) == 0) && !wr_r && (m_st != M_IDLE)
                && !(m_st == M_RUN && !en_r);
         step(en_r, os_r, rt_r, wr_r, sy_r, rs_r);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
